bcd_seg_scanner: RTL and testbench

Downstream consumer of the 8-bit binary-to-BCD converter. Takes the 12-bit, three-digit BCD word over a valid/ready handshake and drives a time-multiplexed, three-digit, common-anode seven-segment display. A shadow register buffers one pending value, and the block swaps it in only at a scan-frame boundary, so the display never tears between digits.

---
 rtl/bcd_seg_scanner.sv | 145 ++++++++++++++
 tb/tb_bcd_seg_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner.sv
// Three-digit multiplexed common-anode seven-segment scanner fed by a BCD valid/ready stream.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module bcd_seg_scanner #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        err
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [PW-1:0] pcnt_reg, pcnt_next;
    logic [1:0]    dig_reg, dig_next;
    logic [11:0]   active_reg, active_next;
    logic [11:0]   shadow_reg, shadow_next;
    logic          shadow_full_reg, shadow_full_next;
    logic          ready_reg;
    logic [6:0]    seg_reg;
    logic [2:0]    an_reg;
    logic          err_reg;

    logic          pcnt_tc;
    logic          frame_end;
    logic          accept;
    logic [2:0]    nib_over;
    logic [6:0]    nib_seg [3];
    logic [6:0]    seg_sel;
    logic [2:0]    an_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [3:0] nib;
            logic       blank;
            assign nib          = active_reg[4*gi +: 4];
            assign nib_over[gi] = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 2) begin : g_blank_h
                assign blank = (nib == 4'd0);
            end else if (gi == 1) begin : g_blank_t
                assign blank = (nib == 4'd0) && (active_reg[11:8] == 4'd0);
            end else begin : g_blank_o
                assign blank = 1'b0;
            end
`else
            assign blank = 1'b0;
`endif
            assign nib_seg[gi] = blank ? SEG_BLANK : seg_decode(nib);
        end
    endgenerate

    assign pcnt_tc   = (pcnt_reg == PCNT_LAST);
    assign frame_end = pcnt_tc && (dig_reg == DIG_HUNDREDS);
    assign accept    = bcd_valid && ready_reg;

    always_comb begin
        pcnt_next        = pcnt_reg + 1'b1;
        dig_next         = dig_reg;
        active_next      = active_reg;
        shadow_next      = shadow_reg;
        shadow_full_next = shadow_full_reg;
        if (pcnt_tc) begin
            pcnt_next = '0;
            dig_next  = (dig_reg == DIG_HUNDREDS) ? DIG_ONES : dig_reg + 2'd1;
        end
        // An accept implies an empty shadow, so it can never collide with a transfer.
        if (accept) begin
            shadow_next      = bcd_in;
            shadow_full_next = 1'b1;
        end else if (frame_end && shadow_full_reg) begin
            active_next      = shadow_reg;
            shadow_full_next = 1'b0;
        end
    end

    always_comb begin
        seg_sel = SEG_BLANK;
        an_sel  = 3'b111;
        case (dig_reg)
            DIG_ONES:     begin seg_sel = nib_seg[0]; an_sel = 3'b110; end
            DIG_TENS:     begin seg_sel = nib_seg[1]; an_sel = 3'b101; end
            DIG_HUNDREDS: begin seg_sel = nib_seg[2]; an_sel = 3'b011; end
            default:      begin seg_sel = SEG_BLANK;  an_sel = 3'b111; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_reg        <= '0;
            dig_reg         <= DIG_ONES;
            active_reg      <= '0;
            shadow_reg      <= '0;
            shadow_full_reg <= 1'b0;
            ready_reg       <= 1'b0;
            seg_reg         <= SEG_BLANK;
            an_reg          <= 3'b111;
            err_reg         <= 1'b0;
        end else begin
            pcnt_reg        <= pcnt_next;
            dig_reg         <= dig_next;
            active_reg      <= active_next;
            shadow_reg      <= shadow_next;
            shadow_full_reg <= shadow_full_next;
            // Registered so that ready stays low throughout reset yet tracks the shadow afterwards.
            ready_reg       <= !shadow_full_next;
            seg_reg         <= seg_sel;
            an_reg          <= an_sel;
            err_reg         <= |nib_over;
        end
    end

    assign bcd_ready = ready_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: frame-level reference model checked every cycle, vector table and corner sequences.
module tb_bcd_seg_scanner;
    localparam int RD = 4;
    localparam int FR = 3 * RD;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_seg_scanner #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [6:0] lut(input int n);
        case (n)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Digit d of value v as it should appear on the display (0 ones, 1 tens, 2 hundreds).
    function automatic logic [6:0] ref_digit(input logic [11:0] v, input int d);
        int n = (int'(v) >> (4 * d)) & 15;
        int h = (int'(v) >> 8) & 15;
        if (n > 9) return 7'h3F;
        if (LZB && d == 2 && n == 0) return 7'h7F;
        if (LZB && d == 1 && n == 0 && h == 0) return 7'h7F;
        return lut(n);
    endfunction

    function automatic logic any_bad(input logic [11:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
    endfunction

    function automatic int dig_of(input int m);
        return (m / RD) % 3;
    endfunction

    // Reference model: mk counts edges since reset release; digit and frame phase follow from it.
    int          mk = 0;
    logic [11:0] m_act = 12'h000;
    logic [11:0] m_sh = 12'h000;
    logic        m_full = 1'b0;
    logic [6:0]  e_seg;
    logic [2:0]  e_an;
    logic        e_err;
    logic        e_rdy = 1'b0;
    logic        mon_en = 1'b0;

    always @(posedge clk) begin
        mon_en <= 1'b1;
        if (!rst_n) begin
            mk     <= 0;
            m_act  <= 12'h000;
            m_full <= 1'b0;
            e_seg  <= 7'h7F;
            e_an   <= 3'b111;
            e_err  <= 1'b0;
            e_rdy  <= 1'b0;
        end else begin
            e_an  <= ~(3'b001 << dig_of(mk));
            e_seg <= ref_digit(m_act, dig_of(mk));
            e_err <= any_bad(m_act);
            if (bcd_valid && e_rdy) begin
                m_sh   <= bcd_in;
                m_full <= 1'b1;
                e_rdy  <= 1'b0;
            end else if (m_full && (mk % FR == FR - 1)) begin
                m_act  <= m_sh;
                m_full <= 1'b0;
                e_rdy  <= 1'b1;
            end else begin
                e_rdy <= !m_full;
            end
            mk <= mk + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_seg", int'(seg), int'(e_seg));
            chk("mon_an", int'(an), int'(e_an));
            chk("mon_err", int'(err), int'(e_err));
            chk("mon_ready", int'(bcd_ready), int'(e_rdy));
        end
    end

    task automatic load(input logic [11:0] v);
        int n = 0;
        @(negedge clk);
        bcd_in    = v;
        bcd_valid = 1'b1;
        while (!bcd_ready && n < 4 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4 * FR) timeout("load");
        @(negedge clk);
        bcd_valid = 1'b0;
        $display("load 0x%03h accepted at %0t", v, $time);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bcd_ready && n < 4 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4 * FR) timeout("wait_ready");
    endtask

    task automatic capture(input int cycles, output logic [6:0] h, output logic [6:0] t,
                           output logic [6:0] o);
        h = 7'h55;
        t = 7'h55;
        o = 7'h55;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            case (an)
                3'b110: o = seg;
                3'b101: t = seg;
                3'b011: h = seg;
                default: ;
            endcase
        end
    endtask

    task automatic chk_frame(input string name, input logic [6:0] h, input logic [6:0] t,
                             input logic [6:0] o, input logic [6:0] eh, input logic [6:0] et,
                             input logic [6:0] eo);
        chk({name, "_h"}, int'(h), int'(eh));
        chk({name, "_t"}, int'(t), int'(et));
        chk({name, "_o"}, int'(o), int'(eo));
        $display("frame %s: h=%02h t=%02h o=%02h", name, h, t, o);
    endtask

    typedef struct {
        logic [11:0] v;
        logic [6:0]  h;
        logic [6:0]  t;
        logic [6:0]  o;
        logic        e;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [6:0] ch, ct, co;
        logic [6:0] zb;
        logic [11:0] v;
        int n;
        zb = LZB ? 7'h7F : 7'h40;
        tbl[0] = '{12'h153, 7'h79, 7'h12, 7'h30, 1'b0};
        tbl[1] = '{12'h0A3, zb,    7'h3F, 7'h30, 1'b1};
        tbl[2] = '{12'h003, zb,    zb,    7'h30, 1'b0};
        tbl[3] = '{12'h042, zb,    7'h19, 7'h24, 1'b0};
        tbl[4] = '{12'h987, 7'h10, 7'h00, 7'h78, 1'b0};
        tbl[5] = '{12'hF0F, 7'h3F, 7'h40, 7'h3F, 1'b1};
        tbl[6] = '{12'h000, zb,    zb,    7'h40, 1'b0};

        // Reset for two cycles, then release.
        repeat (2) begin
            @(negedge clk);
            chk("rst_seg", int'(seg), 'h7F);
            chk("rst_an", int'(an), 'b111);
            chk("rst_ready", int'(bcd_ready), 0);
            chk("rst_err", int'(err), 0);
        end
        rst_n = 1'b1;
        capture(FR, ch, ct, co);
        chk_frame("post_reset", ch, ct, co, zb, zb, 7'h40);
        chk("post_reset_ready", int'(bcd_ready), 1);

        // Vector table: load, wait for transfer, capture one full frame.
        repeat (5) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            load(tbl[i].v);
            chk($sformatf("vec%0d_ready_low", i), int'(bcd_ready), 0);
            wait_ready();
            capture(FR, ch, ct, co);
            chk_frame($sformatf("vec%0d", i), ch, ct, co, tbl[i].h, tbl[i].t, tbl[i].o);
            chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].e));
        end

        // Back-pressure: 099 is held on the bus until 255 has been transferred.
        load(12'h255);
        load(12'h099);
        chk("bp_ready_low", int'(bcd_ready), 0);
        capture(FR - 1, ch, ct, co);
        chk_frame("bp_first", ch, ct, co, 7'h24, 7'h12, 7'h12);
        wait_ready();
        capture(FR, ch, ct, co);
        chk_frame("bp_second", ch, ct, co, zb, 7'h10, 7'h10);

        // Reset while a value is pending and the tens digit is being scanned.
        n = 0;
        while (dig_of(mk) != 0 && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        load(12'h777);
        n = 0;
        while (dig_of(mk) != 1 && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FR) timeout("wait_dig1");
        chk("mid_rst_pending", int'(bcd_ready), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_seg", int'(seg), 'h7F);
        chk("mid_rst_an", int'(an), 'b111);
        chk("mid_rst_ready", int'(bcd_ready), 0);
        chk("mid_rst_err", int'(err), 0);
        rst_n = 1'b1;
        capture(FR, ch, ct, co);
        chk_frame("mid_rst_f1", ch, ct, co, zb, zb, 7'h40);
        capture(FR, ch, ct, co);
        chk_frame("mid_rst_f2", ch, ct, co, zb, zb, 7'h40);
        chk("mid_rst_ready_up", int'(bcd_ready), 1);

        // Random loads at random frame phases, with ignored valid pulses while busy.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            if (!bcd_ready && $urandom_range(0, 2) == 0) begin
                bcd_in    = 12'($urandom);
                bcd_valid = 1'b1;
                @(negedge clk);
                bcd_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0)
                v = 12'($urandom);
            else
                v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            load(v);
        end
        wait_ready();
        repeat (FR + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
